// File: rtl/elastic_register_pipeline.sv
// Elastic register pipeline: PIPE_DEPTH stages of WORD_WIDTH data plus a valid
// bit, with a combinational bubble-collapsing ready chain, flush, parallel
// load/observe, global clock enable and a registered-state occupancy count.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both 1 in the cycle before that edge. Valid never waits
// on ready. in_ready_o depends combinationally on out_ready_i through the
// open-stage chain. During a flush or parallel-load cycle, out_valid_o still
// shows the pre-edge state, but the word is not delivered.
module elastic_register_pipeline #(
    parameter int                               WORD_WIDTH   = 8,
    parameter int                               PIPE_DEPTH   = 4,
    parameter logic [WORD_WIDTH*PIPE_DEPTH-1:0] RESET_VALUES = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clk_en_i,
    input  logic                               flush_i,
    input  logic                               parallel_load_i,
    input  logic [WORD_WIDTH*PIPE_DEPTH-1:0]   parallel_i,
    input  logic [PIPE_DEPTH-1:0]              parallel_valid_i,
    output logic [WORD_WIDTH*PIPE_DEPTH-1:0]   parallel_o,
    output logic [PIPE_DEPTH-1:0]              parallel_valid_o,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [WORD_WIDTH-1:0]              in_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [WORD_WIDTH-1:0]              out_data_o,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]    occupancy_o
);

    localparam int OW = $clog2(PIPE_DEPTH + 1);

    logic [PIPE_DEPTH-1:0][WORD_WIDTH-1:0] data_q, data_d;
    logic [PIPE_DEPTH-1:0]                 valid_q, valid_d;
    logic [PIPE_DEPTH-1:0]                 open_w;
    logic [OW-1:0]                         occ_w;

    // Ready chain: a stage is open when empty or when the stage after it opens.
    always_comb begin
        logic carry;
        carry  = out_ready_i;
        open_w = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            carry     = !valid_q[k] || carry;
            open_w[k] = carry;
        end
    end

    // Next-state: flush beats parallel load, which beats normal shifting.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (parallel_load_i) begin
            data_d  = parallel_i;
            valid_d = parallel_valid_i;
        end else begin
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (open_w[k]) begin
                    data_d[k]  = data_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
            end
            if (open_w[0]) begin
                data_d[0]  = in_data_i;
                valid_d[0] = in_valid_i;
            end
        end
    end

    // Stage registers; clk_en_i low freezes everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= RESET_VALUES;
            valid_q <= '0;
        end else if (clk_en_i) begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Population count of the registered valid bits.
    always_comb begin
        occ_w = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            occ_w = occ_w + OW'(valid_q[k]);
        end
    end

    assign in_ready_o       = clk_en_i && !flush_i && !parallel_load_i && open_w[0];
    assign out_valid_o      = clk_en_i && valid_q[PIPE_DEPTH-1];
    assign out_data_o       = data_q[PIPE_DEPTH-1];
    assign parallel_o       = data_q;
    assign parallel_valid_o = valid_q;
    assign occupancy_o      = occ_w;

endmodule

// File: tb/tb_elastic_register_pipeline.sv
// Bench for elastic_register_pipeline (8-bit words, 4 stages, reset A3A2A1A0).
// Drivers push expected words into exp_q on acceptance; a monitor pops and
// compares on every delivered word.
module tb_elastic_register_pipeline;

    localparam int W = 8;
    localparam int D = 4;
    localparam logic [W*D-1:0] RV = 32'hA3A2A1A0;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           clk_en_i = 1'b1;
    logic           flush_i = 1'b0;
    logic           parallel_load_i = 1'b0;
    logic [W*D-1:0] parallel_i = '0;
    logic [D-1:0]   parallel_valid_i = '0;
    logic [W*D-1:0] parallel_o;
    logic [D-1:0]   parallel_valid_o;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [W-1:0]   in_data_i = '0;
    logic           out_valid_o;
    logic           out_ready_i = 1'b0;
    logic [W-1:0]   out_data_o;
    logic [2:0]     occupancy_o;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int del_cyc = -1;

    elastic_register_pipeline #(
        .WORD_WIDTH(W), .PIPE_DEPTH(D), .RESET_VALUES(RV)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clk_en_i(clk_en_i), .flush_i(flush_i),
        .parallel_load_i(parallel_load_i), .parallel_i(parallel_i),
        .parallel_valid_i(parallel_valid_i), .parallel_o(parallel_o),
        .parallel_valid_o(parallel_valid_o), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .occupancy_o(occupancy_o)
    );

    // clock / cycle counter
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one word starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [W-1:0] w);
        int budget;
        in_valid_i = 1'b1;
        in_data_i  = w;
        #1;
        budget = 0;
        while (!in_ready_o && budget < 40) begin
            @(negedge clk_i);
            #1;
            budget++;
        end
        if (!in_ready_o) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: word %h never accepted", w);
        end else begin
            exp_q.push_back(w);
            if (w == 8'h01) acc_cyc = cyc;
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(negedge clk_i);
            budget++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
        end
    endtask

    // monitor: sample late in each cycle, just before the transfer edge
    initial begin
        forever begin
            @(negedge clk_i);
            #3;
            if (out_valid_o && out_ready_i && !flush_i && !parallel_load_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected: got %h expected none", out_data_o);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data_o !== e) begin
                        n_err++;
                        $display("FAIL out_data: got %h expected %h", out_data_o, e);
                    end
                end
                if (out_data_o == 8'h01) del_cyc = cyc;
            end
        end
    end

    initial begin
        // reset
        repeat (3) @(negedge clk_i);
        chk("rst_parallel_o", parallel_o, RV);
        chk("rst_pvalid", {28'd0, parallel_valid_o}, 32'h0);
        chk("rst_occ", {29'd0, occupancy_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_out_data", {24'd0, out_data_o}, 32'hA3);
        rst_ni = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);

        // streaming 01..08 with out_ready high
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) send(W'(i));
        drain();
        chk("stream_latency", del_cyc - acc_cyc, 32'd4);

        // backpressure and bubble collapse
        out_ready_i = 1'b0;
        send(8'h11);
        repeat (2) @(negedge clk_i);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        #1;
        chk("bp_occ", {29'd0, occupancy_o}, 32'd4);
        chk("bp_pvalid", {28'd0, parallel_valid_o}, 32'hF);
        chk("bp_parallel_o", parallel_o, 32'h11223344);
        in_valid_i = 1'b1;
        in_data_i  = 8'h55;
        #1;
        chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        chk("bp_occ_hold", {29'd0, occupancy_o}, 32'd4);
        chk("bp_data_hold", parallel_o, 32'h11223344);
        @(negedge clk_i);
        out_ready_i = 1'b1;
        drain();

        // parallel load with a competing input word
        out_ready_i      = 1'b0;
        parallel_load_i  = 1'b1;
        parallel_i       = 32'h44332211;
        parallel_valid_i = 4'b0101;
        in_valid_i       = 1'b1;
        in_data_i        = 8'hEE;
        #1;
        chk("pl_in_ready", {31'd0, in_ready_o}, 32'd0);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h11);
        @(negedge clk_i);
        parallel_load_i = 1'b0;
        in_valid_i      = 1'b0;
        #1;
        chk("pl_pvalid", {28'd0, parallel_valid_o}, 32'h5);
        chk("pl_occ", {29'd0, occupancy_o}, 32'd2);
        chk("pl_parallel_o", parallel_o, 32'h44332211);
        @(negedge clk_i);
        out_ready_i = 1'b1;
        drain();

        // flush together with load on a full pipe
        out_ready_i = 1'b0;
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        #1;
        chk("fl_full", {28'd0, parallel_valid_o}, 32'hF);
        flush_i          = 1'b1;
        parallel_load_i  = 1'b1;
        parallel_i       = 32'hFFFFFFFF;
        parallel_valid_i = 4'hF;
        @(negedge clk_i);
        flush_i         = 1'b0;
        parallel_load_i = 1'b0;
        exp_q.delete();
        #1;
        chk("fl_pvalid", {28'd0, parallel_valid_o}, 32'h0);
        chk("fl_occ", {29'd0, occupancy_o}, 32'd0);
        chk("fl_data_kept", parallel_o, 32'hA1A2A3A4);
        @(negedge clk_i);

        // clock enable low freezes state
        send(8'hB1);
        send(8'hB2);
        repeat (3) @(negedge clk_i);
        chk("ce_pre_pvalid", {28'd0, parallel_valid_o}, 32'hC);
        clk_en_i    = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h77;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ce_in_ready", {31'd0, in_ready_o}, 32'd0);
            chk("ce_out_valid", {31'd0, out_valid_o}, 32'd0);
            @(negedge clk_i);
        end
        chk("ce_post_pvalid", {28'd0, parallel_valid_o}, 32'hC);
        chk("ce_post_out_data", {24'd0, out_data_o}, 32'hB1);
        in_valid_i = 1'b0;
        clk_en_i   = 1'b1;
        drain();

        // asynchronous reset mid-stream
        out_ready_i = 1'b0;
        send(8'hC1); send(8'hC2); send(8'hC3);
        #1;
        chk("ar_occ_pre", {29'd0, occupancy_o}, 32'd3);
        #1;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("ar_parallel_o", parallel_o, RV);
        chk("ar_pvalid", {28'd0, parallel_valid_o}, 32'h0);
        chk("ar_occ", {29'd0, occupancy_o}, 32'd0);
        chk("ar_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("ar_out_data", {24'd0, out_data_o}, 32'hA3);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        #1;
        chk("ar_in_ready", {31'd0, in_ready_o}, 32'd1);
        send(8'hD1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/elastic_register_pipeline.md
ELASTIC_REGISTER_PIPELINE -- requirements
Module: elastic_register_pipeline

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, bits per stage word (legal range >= 1).
REQ-002 SHALL have parameter PIPE_DEPTH, default 4, number of register stages (legal range >= 1).
REQ-003 SHALL have parameter RESET_VALUES, width WORD_WIDTH*PIPE_DEPTH, default 0, per-stage data reset value; stage k uses bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-004 SHALL have ports as follows; TW = WORD_WIDTH*PIPE_DEPTH, OW = clog2(PIPE_DEPTH+1). Clock is clk_i. Reset is rst_ni, asynchronous, active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- clk_en_i  in  1  global enable; 0 freezes all state.
- flush_i  in  1  clears all stage valid bits.
- parallel_load_i  in  1  loads all stages from parallel_i.
- parallel_i  in  TW  parallel load data, stage k at slice k.
- parallel_valid_i  in  PIPE_DEPTH  per-stage valid for parallel load.
- parallel_o  out  TW  all stage data, stage k at slice k.
- parallel_valid_o  out  PIPE_DEPTH  per-stage valid bits.
- in_valid_i  in  1  upstream word valid.
- in_ready_o  out  1  pipeline accepts a word this cycle.
- in_data_i  in  WORD_WIDTH  upstream word.
- out_valid_o  out  1  last stage holds a deliverable word.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  WORD_WIDTH  last-stage data.
- occupancy_o  out  OW  count of valid stages.

Function
REQ-005 Stage 0 SHALL be the input stage and stage PIPE_DEPTH-1 the output stage; each stage SHALL hold a data word and a valid bit.
REQ-006 Stage k SHALL be "open" when valid[k]=0 or stage k+1 is open; stage PIPE_DEPTH SHALL be treated as open when out_ready_i=1 (bubble-collapsing, combinational ready chain).
REQ-007 in_ready_o SHALL equal clk_en_i AND NOT flush_i AND NOT parallel_load_i AND stage 0 open.
REQ-008 out_valid_o SHALL equal clk_en_i AND valid[PIPE_DEPTH-1]; out_data_o SHALL equal stage PIPE_DEPTH-1 data regardless of valid.
REQ-009 Normal operation (clk_en_i=1, flush_i=0, parallel_load_i=0): on each rising edge every open stage k>0 SHALL capture data/valid of stage k-1, and stage 0 (if open) SHALL capture in_data_i with valid = in_valid_i; closed stages SHALL hold.
REQ-010 A word accepted (in_valid_i & in_ready_o) into an empty pipeline with out_ready_i held 1 SHALL appear on out_valid_o exactly PIPE_DEPTH cycles later; sustained throughput SHALL be one word per cycle.
REQ-011 Words SHALL never be dropped, duplicated or reordered; a stage SHALL be overwritten only when open.
REQ-012 Bubbles SHALL collapse: with out_ready_i=0, newly accepted words SHALL advance until they meet an occupied stage, so the pipeline fills to PIPE_DEPTH words before in_ready_o deasserts.
REQ-013 Precedence SHALL be: clk_en_i=0 (hold everything) > flush_i > parallel_load_i > normal operation.
REQ-014 flush_i=1 with clk_en_i=1 SHALL clear all valid bits at the next edge and leave data registers unchanged; no output transfer SHALL be counted that cycle (out_valid_o still reflects pre-flush state; downstream may sample it).
REQ-015 parallel_load_i=1 with clk_en_i=1 (no flush) SHALL load every stage k with parallel_i slice k and valid[k]=parallel_valid_i[k] at the next edge, discarding prior contents; in_valid_i SHALL be ignored that cycle.
REQ-016 parallel_o and parallel_valid_o SHALL reflect register contents directly (no gating by clk_en_i).
REQ-017 occupancy_o SHALL equal the population count of the valid bits, registered-state derived, range 0..PIPE_DEPTH.
REQ-018 PIPE_DEPTH=1 SHALL operate as a single elastic register with identical rules.

Reset
REQ-019 While rst_ni=0, asynchronously: all valid bits 0, stage k data = RESET_VALUES slice k, out_valid_o=0, occupancy_o=0, parallel_valid_o=0, parallel_o=RESET_VALUES, out_data_o = RESET_VALUES top slice.
REQ-020 Reset asserted mid-transfer SHALL discard all in-flight words; first acceptance SHALL be possible in the first cycle after rst_ni deasserts.

Verification (WORD_WIDTH=8, PIPE_DEPTH=4, RESET_VALUES=32'hA3A2A1A0)
REQ-021 Reset: rst_ni=0 -> parallel_o=A3A2A1A0, parallel_valid_o=0000, occupancy_o=0, in_ready_o=1 after release with clk_en_i=1.
REQ-022 Streaming: push 0x01..0x08 back-to-back, out_ready_i=1 -> 0x01 at out_valid_o on cycle 4 after acceptance, then one word per cycle in order.
REQ-023 Backpressure/bubble: out_ready_i=0, push 0x11 then idle 2 cycles then 0x22,0x33,0x44 -> occupancy_o reaches 4, in_ready_o=0, parallel_valid_o=1111; release out_ready_i -> drains 0x11,0x22,0x33,0x44 in order.
REQ-024 Parallel load: parallel_i=0x44332211, parallel_valid_i=0101, simultaneous in_valid_i=1 with 0xEE -> next cycle parallel_valid_o=0101, 0xEE not accepted (in_ready_o=0), occupancy_o=2; drain yields 0x33 then 0x11.
REQ-025 Flush vs load and enable: flush_i=1 and parallel_load_i=1 together on a full pipe -> all valid 0, data unchanged; clk_en_i=0 for 3 cycles with in_valid_i=1, out_ready_i=1 -> no state change, in_ready_o=0, out_valid_o=0.
REQ-026 Async reset mid-stream: assert rst_ni between edges with occupancy_o=3 -> outputs return to reset values immediately, no clock edge required.
